mem_access_ctrl: RTL

Memory-access stage controller between the execute stage and the word-level load-store unit. It takes one RV32 load or store per transaction and drives the LSU's word read/write request lines. Sub-word stores are performed as read-modify-write, because the LSU moves full 32-bit words only. Load data is aligned and sign/zero-extended, then a one-cycle result pulse is handed to writeback.

---
 rtl/mem_access_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-access stage controller: one RV32 load/store per transaction onto a
// word-only LSU, with read-modify-write for sub-word stores and load extension.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  output logic        lsu_read_o,
  output logic        lsu_write_o,
  output logic [31:0] lsu_addr_o,
  output logic [31:0] lsu_data_o,
  input  logic [31:0] lsu_data_i,
  input  logic        lsu_valid_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [4:0]  rd_o,
  output logic        rd_we_o,
  output logic        err_o
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, RMW_GAP, STORE, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        lsu_read_q, lsu_read_d;
  logic        lsu_write_q, lsu_write_d;
  logic [31:0] lsu_addr_q, lsu_addr_d;
  logic [31:0] lsu_data_q, lsu_data_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_we_q, rd_we_d;
  logic        err_q, err_d;
  logic        f3_ok, illegal;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   load_ext = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic is_half, input logic [1:0] lane,
                                        input logic [31:0] w, input logic [15:0] wd);
    logic [31:0] m;
    m = w;
    if (is_half) begin
      if (lane[1]) m[31:16] = wd;
      else         m[15:0]  = wd;
    end else begin
      case (lane)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end
    merge = m;
  endfunction

  always_comb begin
    f3_ok   = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
              (funct3_i == 3'b100) || (funct3_i == 3'b101);
    // Halfword check covers both H and HU encodings.
    illegal = (is_load_i == is_store_i) || !f3_ok || (is_store_i && funct3_i[2]) ||
              ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
              ((funct3_i == 3'b010) && (addr_i[1:0] != 2'b00));
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    funct3_d    = funct3_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    lsu_read_d  = lsu_read_q;
    lsu_write_d = lsu_write_q;
    lsu_addr_d  = lsu_addr_q;
    lsu_data_d  = lsu_data_q;
    valid_d     = valid_q;
    rdata_d     = rdata_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          lane_d     = addr_i[1:0];
          funct3_d   = funct3_i;
          wdata_d    = wdata_i[15:0];
          rd_d       = rd_i;
          lsu_addr_d = {addr_i[31:2], 2'b00};
          if (illegal) begin
            state_d = DONE;
            valid_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'b0;
            rd_we_d = 1'b0;
          end else if (is_load_i) begin
            state_d    = LOAD;
            lsu_read_d = 1'b1;
          end else if (funct3_i == 3'b010) begin
            state_d     = STORE;
            lsu_write_d = 1'b1;
            lsu_data_d  = wdata_i;
          end else begin
            state_d    = RMW_RD;
            lsu_read_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (lsu_valid_i) begin
          state_d    = DONE;
          lsu_read_d = 1'b0;
          rdata_d    = load_ext(funct3_q, lane_q, lsu_data_i);
          rd_we_d    = 1'b1;
          valid_d    = 1'b1;
        end
      end
      RMW_RD: begin
        if (lsu_valid_i) begin
          state_d    = RMW_GAP;
          lsu_read_d = 1'b0;
          word_d     = lsu_data_i;
        end
      end
      // One idle cycle between the read and the write lets the LSU settle.
      RMW_GAP: begin
        state_d     = STORE;
        lsu_write_d = 1'b1;
        lsu_data_d  = merge(funct3_q[0], lane_q, word_q, wdata_q);
      end
      STORE: begin
        if (lsu_valid_i) begin
          state_d     = DONE;
          lsu_write_d = 1'b0;
          rdata_d     = 32'b0;
          valid_d     = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        valid_d = 1'b0;
        err_d   = 1'b0;
        rd_we_d = 1'b0;
        rdata_d = 32'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      lane_q      <= 2'b0;
      funct3_q    <= 3'b0;
      wdata_q     <= 16'b0;
      word_q      <= 32'b0;
      lsu_read_q  <= 1'b0;
      lsu_write_q <= 1'b0;
      lsu_addr_q  <= 32'b0;
      lsu_data_q  <= 32'b0;
      valid_q     <= 1'b0;
      rdata_q     <= 32'b0;
      rd_q        <= 5'b0;
      rd_we_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      lsu_read_q  <= lsu_read_d;
      lsu_write_q <= lsu_write_d;
      lsu_addr_q  <= lsu_addr_d;
      lsu_data_q  <= lsu_data_d;
      valid_q     <= valid_d;
      rdata_q     <= rdata_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      err_q       <= err_d;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign lsu_read_o  = lsu_read_q;
  assign lsu_write_o = lsu_write_q;
  assign lsu_addr_o  = lsu_addr_q;
  assign lsu_data_o  = lsu_data_q;
  assign valid_o     = valid_q;
  assign rdata_o     = rdata_q;
  assign rd_o        = rd_q;
  assign rd_we_o     = rd_we_q;
  assign err_o       = err_q;

endmodule
